// File: rtl/matrix_scroll_loader.sv
// Scrolling column feeder for the dot-matrix driver.
// Sweeps a COLS-wide window of a pattern RAM into Matrix.
module matrix_scroll_loader #(
  parameter int DEPTH      = 32,
  parameter int AW         = 5,
  parameter int COLS       = 16,
  parameter int SCROLL_DIV = 1000000
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          enable,
  input  logic          refresh,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  output logic [4:0]    column_id,
  output logic [15:0]   in_column,
  output logic          IN_CLR,
  output logic          LOAD,
  output logic          busy,
  output logic [AW-1:0] offset
);

  localparam int CW = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    SWEEP
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic          tick;
  logic          req;
  logic          pending;
  logic          adv;
  logic          start;
  logic          last;
  logic          rd_en;
  logic [AW-1:0] idx;
  logic [AW-1:0] rd_addr;
  logic [15:0]   ram [DEPTH];

  assign tick = enable && (cnt == CW'(SCROLL_DIV - 1));
  assign req  = tick || refresh;
  assign last = (idx == AW'(COLS - 1));
  assign column_id = 5'(idx);

  always_comb begin
    state_nx = state;
    IN_CLR   = 1'b0;
    LOAD     = 1'b0;
    busy     = 1'b0;
    rd_en    = 1'b0;
    start    = 1'b0;
    rd_addr  = offset;
    unique case (state)
      IDLE: begin
        if (pending || req) begin
          state_nx = CLR;
          start    = 1'b1;
        end
      end
      CLR: begin
        IN_CLR   = 1'b1;
        busy     = 1'b1;
        rd_en    = 1'b1;
        state_nx = SWEEP;
      end
      SWEEP: begin
        LOAD    = 1'b1;
        busy    = 1'b1;
        // prefetch the next column while this one is on the bus
        rd_addr = offset + idx + AW'(1);
        rd_en   = !last;
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        cnt <= '0;
    else if (!enable) cnt <= '0;
    else if (tick)    cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  // requests during a sweep merge into one follow-up sweep
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending <= 1'b0;
      adv     <= 1'b0;
      offset  <= '0;
    end else if (start) begin
      pending <= 1'b0;
      adv     <= 1'b0;
      offset  <= offset + {{(AW-1){1'b0}}, adv | tick};
    end else if (state != IDLE) begin
      pending <= pending | req;
      adv     <= adv | tick;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx       <= '0;
      in_column <= '0;
    end else begin
      if (state == CLR)
        idx <= '0;
      else if (state == SWEEP && !last)
        idx <= idx + AW'(1);
      if (rd_en)
        in_column <= ram[rd_addr];
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

endmodule
